// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage hazard controller with long-op scoreboard
// Detects RAW/WAW/structural hazards, tracks one variable-latency GPR write, counts stall cycles.
module hazard_scoreboard #(
  parameter int REG_W        = 5,
  parameter int LAT_W        = 4,
  parameter int CNT_W        = 32,
  parameter int BRANCH_IN_ID = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_reg_write,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic             id_branch,
  input  logic             id_jr,
  input  logic             id_redirect,
  input  logic             issue_long,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_wr_reg,
  input  logic             mem_mem_read,
  input  logic [REG_W-1:0] mem_wr_reg,
  input  logic             dmem_wait,
  output logic             stall,
  output logic             id_flush,
  output logic             if_flush,
  output logic             freeze,
  output logic             lu_busy,
  output logic             lu_wb,
  output logic [REG_W-1:0] lu_wb_reg,
  output logic [CNT_W-1:0] stall_count
);

  logic             lu_busy_q, lu_busy_d;
  logic [REG_W-1:0] lu_wb_reg_q, lu_wb_reg_d;
  logic [LAT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic m_ex, m_mem, m_lu, br;
  logic h1, h2, h3, h4, h5, h6;
  logic hz, frz, stl, accept, wb;

  function automatic logic rd_match(input logic [REG_W-1:0] x, input logic [REG_W-1:0] rs,
                                    input logic [REG_W-1:0] rt, input logic urs, input logic urt);
    return (x != '0) && ((urs && (rs == x)) || (urt && (rt == x)));
  endfunction

  always_comb begin
    frz    = dmem_wait & ~reset;
    m_ex   = rd_match(ex_wr_reg, id_rs, id_rt, id_uses_rs, id_uses_rt);
    m_mem  = rd_match(mem_wr_reg, id_rs, id_rt, id_uses_rs, id_uses_rt);
    m_lu   = rd_match(lu_wb_reg_q, id_rs, id_rt, id_uses_rs, id_uses_rt);
    br     = (id_branch | id_jr) & (BRANCH_IN_ID != 0);
    h1     = ex_mem_read & m_ex;
    h2     = br & ex_reg_write & m_ex;
    h3     = br & mem_mem_read & m_mem;
    h4     = lu_busy_q & m_lu;
    h5     = lu_busy_q & id_reg_write & (id_wr_reg == lu_wb_reg_q) & (lu_wb_reg_q != '0);
    h6     = lu_busy_q & issue_long & (lu_cnt_q > LAT_W'(1));
    hz     = id_valid & ~reset & (h1 | h2 | h3 | h4 | h5 | h6);
    stl    = frz | hz;
    accept = issue_long & id_valid & ~stl & ~reset;
    wb     = lu_busy_q & (lu_cnt_q == LAT_W'(1)) & ~frz & ~reset;

    lu_busy_d   = lu_busy_q;
    lu_wb_reg_d = lu_wb_reg_q;
    lu_cnt_d    = lu_cnt_q;
    if (lu_busy_q && !frz) begin
      lu_cnt_d = lu_cnt_q - LAT_W'(1);
      if (wb) lu_busy_d = 1'b0;
    end
    // A new accept overrides the retiring entry, enabling back-to-back issue
    if (accept) begin
      lu_busy_d   = 1'b1;
      lu_wb_reg_d = id_wr_reg;
      lu_cnt_d    = (issue_lat == '0) ? LAT_W'(1) : issue_lat;
    end

    stall_count_d = stall_count_q;
    if (stl && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lu_busy_q     <= 1'b0;
      lu_wb_reg_q   <= '0;
      lu_cnt_q      <= '0;
      stall_count_q <= '0;
    end else begin
      lu_busy_q     <= lu_busy_d;
      lu_wb_reg_q   <= lu_wb_reg_d;
      lu_cnt_q      <= lu_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign freeze      = frz;
  assign stall       = stl;
  assign id_flush    = hz & ~frz;
  assign if_flush    = id_redirect & id_valid & ~stl & ~reset;
  assign lu_busy     = lu_busy_q;
  assign lu_wb       = wb;
  assign lu_wb_reg   = lu_wb_reg_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_branch, id_jr, id_redirect;
  logic [4:0] id_rs, id_rt, id_wr_reg, ex_wr_reg, mem_wr_reg;
  logic       issue_long, ex_reg_write, ex_mem_read, mem_mem_read, dmem_wait;
  logic [3:0] issue_lat;

  logic        stall, id_flush, if_flush, freeze, lu_busy, lu_wb;
  logic [4:0]  lu_wb_reg;
  logic [31:0] stall_count;
  logic        s1_stall, s1_id_flush, s1_if_flush, s1_freeze, s1_lu_busy, s1_lu_wb;
  logic [4:0]  s1_lu_wb_reg;
  logic [1:0]  s1_stall_count;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  hazard_scoreboard #(.REG_W(5), .LAT_W(4), .CNT_W(32), .BRANCH_IN_ID(1)) u0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_wr_reg(id_wr_reg), .id_branch(id_branch), .id_jr(id_jr), .id_redirect(id_redirect),
    .issue_long(issue_long), .issue_lat(issue_lat), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_wr_reg(ex_wr_reg), .mem_mem_read(mem_mem_read),
    .mem_wr_reg(mem_wr_reg), .dmem_wait(dmem_wait), .stall(stall), .id_flush(id_flush),
    .if_flush(if_flush), .freeze(freeze), .lu_busy(lu_busy), .lu_wb(lu_wb),
    .lu_wb_reg(lu_wb_reg), .stall_count(stall_count));

  hazard_scoreboard #(.REG_W(5), .LAT_W(4), .CNT_W(2), .BRANCH_IN_ID(0)) u1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_wr_reg(id_wr_reg), .id_branch(id_branch), .id_jr(id_jr), .id_redirect(id_redirect),
    .issue_long(issue_long), .issue_lat(issue_lat), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_wr_reg(ex_wr_reg), .mem_mem_read(mem_mem_read),
    .mem_wr_reg(mem_wr_reg), .dmem_wait(dmem_wait), .stall(s1_stall), .id_flush(s1_id_flush),
    .if_flush(s1_if_flush), .freeze(s1_freeze), .lu_busy(s1_lu_busy), .lu_wb(s1_lu_wb),
    .lu_wb_reg(s1_lu_wb_reg), .stall_count(s1_stall_count));

  task automatic clear_inputs();
    id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_reg_write = 0; id_branch = 0;
    id_jr = 0; id_redirect = 0; id_rs = 0; id_rt = 0; id_wr_reg = 0; ex_wr_reg = 0;
    mem_wr_reg = 0; issue_long = 0; issue_lat = 0; ex_reg_write = 0; ex_mem_read = 0;
    mem_mem_read = 0; dmem_wait = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [3:0] lat);
    clear_inputs();
    id_valid = 1; issue_long = 1; issue_lat = lat; id_reg_write = 1; id_wr_reg = rd;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; dmem_wait = 1; id_valid = 1; id_redirect = 1;
    step(); step();
    checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL reset_freeze: got %b exp 0", freeze); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", stall); end
    checks++; if (if_flush !== 1'b0) begin errors++; $display("FAIL reset_if_flush: got %b exp 0", if_flush); end
    clear_inputs();
    reset = 0;
    #1;
    checks++; if (lu_busy !== 1'b0) begin errors++; $display("FAIL reset_lu_busy: got %b exp 0", lu_busy); end
    checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", stall_count); end
    checks++; if (lu_wb_reg !== 5'd0) begin errors++; $display("FAIL reset_wb_reg: got %0d exp 0", lu_wb_reg); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    id_valid = 1; ex_mem_read = 1; ex_wr_reg = 8; id_uses_rs = 1; id_rs = 8;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b exp 1", stall); end
    checks++; if (id_flush !== 1'b1) begin errors++; $display("FAIL lu_id_flush: got %b exp 1", id_flush); end
    step();
    clear_inputs();
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %b exp 0", stall); end
    checks++; if (stall_count !== 32'd1) begin errors++; $display("FAIL lu_count: got %0d exp 1", stall_count); end
    id_valid = 1; ex_mem_read = 1; ex_wr_reg = 0; id_uses_rs = 1; id_rs = 0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_reg0: got %b exp 0", stall); end
    ex_wr_reg = 8; id_rs = 8; id_valid = 0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_invalid: got %b exp 0", stall); end
    clear_inputs();
  endtask

  task automatic test_branch();
    clear_inputs();
    id_valid = 1; ex_reg_write = 1; ex_wr_reg = 9; id_branch = 1; id_uses_rt = 1; id_rt = 9;
    id_redirect = 1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL br_alu_stall: got %b exp 1", stall); end
    checks++; if (if_flush !== 1'b0) begin errors++; $display("FAIL br_if_flush_stalled: got %b exp 0", if_flush); end
    checks++; if (s1_stall !== 1'b0) begin errors++; $display("FAIL br_off_stall: got %b exp 0", s1_stall); end
    checks++; if (s1_if_flush !== 1'b1) begin errors++; $display("FAIL br_off_if_flush: got %b exp 1", s1_if_flush); end
    id_branch = 0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL br_nonbranch: got %b exp 0", stall); end
    checks++; if (if_flush !== 1'b1) begin errors++; $display("FAIL br_if_flush: got %b exp 1", if_flush); end
    clear_inputs();
    id_valid = 1; mem_mem_read = 1; mem_wr_reg = 5; id_jr = 1; id_uses_rs = 1; id_rs = 5;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL br_load_stall: got %b exp 1", stall); end
    checks++; if (s1_stall !== 1'b0) begin errors++; $display("FAIL br_off_load: got %b exp 0", s1_stall); end
    clear_inputs();
  endtask

  task automatic test_long_op();
    issue(10, 4);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL long_issue_stall: got %b exp 0", stall); end
    step();
    clear_inputs();
    id_valid = 1; id_uses_rt = 0; id_rt = 10;
    #1;
    checks++; if (lu_busy !== 1'b1) begin errors++; $display("FAIL long_busy: got %b exp 1", lu_busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL long_no_use: got %b exp 0", stall); end
    id_uses_rt = 1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL long_raw_c1: got %b exp 1", stall); end
    step();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL long_raw_c2: got %b exp 1", stall); end
    id_uses_rt = 0; id_reg_write = 1; id_wr_reg = 10;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL long_waw: got %b exp 1", stall); end
    id_uses_rt = 1; id_reg_write = 0; id_wr_reg = 0;
    step();
    checks++; if (lu_wb !== 1'b0) begin errors++; $display("FAIL long_early_wb: got %b exp 0", lu_wb); end
    step();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL long_raw_c4: got %b exp 1", stall); end
    checks++; if (lu_wb !== 1'b1) begin errors++; $display("FAIL long_wb: got %b exp 1", lu_wb); end
    checks++; if (lu_wb_reg !== 5'd10) begin errors++; $display("FAIL long_wb_reg: got %0d exp 10", lu_wb_reg); end
    step();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL long_release: got %b exp 0", stall); end
    checks++; if (lu_busy !== 1'b0) begin errors++; $display("FAIL long_idle: got %b exp 0", lu_busy); end
    checks++; if (stall_count !== 32'd5) begin errors++; $display("FAIL long_count: got %0d exp 5", stall_count); end
    checks++; if (s1_stall_count !== 2'd3) begin errors++; $display("FAIL long_sat: got %0d exp 3", s1_stall_count); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    issue(11, 3);
    step();
    issue(12, 2);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_struct: got %b exp 1", stall); end
    step();
    checks++; if (lu_wb_reg !== 5'd11) begin errors++; $display("FAIL b2b_not_taken: got %0d exp 11", lu_wb_reg); end
    step();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_cnt1_stall: got %b exp 0", stall); end
    checks++; if (lu_wb !== 1'b1) begin errors++; $display("FAIL b2b_wb_old: got %b exp 1", lu_wb); end
    step();
    checks++; if (lu_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b exp 1", lu_busy); end
    checks++; if (lu_wb_reg !== 5'd12) begin errors++; $display("FAIL b2b_new_reg: got %0d exp 12", lu_wb_reg); end
    clear_inputs();
    #1;
    checks++; if (lu_wb !== 1'b0) begin errors++; $display("FAIL b2b_wb_early: got %b exp 0", lu_wb); end
    step();
    checks++; if (lu_wb !== 1'b1) begin errors++; $display("FAIL b2b_wb_new: got %b exp 1", lu_wb); end
    step();
    checks++; if (lu_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b exp 0", lu_busy); end
    checks++; if (stall_count !== 32'd7) begin errors++; $display("FAIL b2b_count: got %0d exp 7", stall_count); end
    checks++; if (s1_stall_count !== 2'd3) begin errors++; $display("FAIL b2b_sat: got %0d exp 3", s1_stall_count); end
  endtask

  task automatic test_freeze();
    issue(13, 4);
    step();
    clear_inputs();
    step(); step();
    dmem_wait = 1; id_valid = 1; id_redirect = 1; id_uses_rs = 1; id_rs = 13;
    #1;
    checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL frz_freeze: got %b exp 1", freeze); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL frz_stall: got %b exp 1", stall); end
    checks++; if (id_flush !== 1'b0) begin errors++; $display("FAIL frz_id_flush: got %b exp 0", id_flush); end
    checks++; if (if_flush !== 1'b0) begin errors++; $display("FAIL frz_if_flush: got %b exp 0", if_flush); end
    step(); step(); step();
    clear_inputs();
    #1;
    checks++; if (lu_wb !== 1'b0) begin errors++; $display("FAIL frz_cnt_held: got %b exp 0", lu_wb); end
    checks++; if (stall_count !== 32'd10) begin errors++; $display("FAIL frz_count: got %0d exp 10", stall_count); end
    step();
    checks++; if (lu_wb !== 1'b1) begin errors++; $display("FAIL frz_wb: got %b exp 1", lu_wb); end
    step();
    checks++; if (lu_busy !== 1'b0) begin errors++; $display("FAIL frz_idle: got %b exp 0", lu_busy); end
  endtask

  task automatic test_reset_mid_op();
    issue(14, 4);
    step();
    clear_inputs();
    step(); step();
    reset = 1;
    #1;
    checks++; if (lu_wb !== 1'b0) begin errors++; $display("FAIL rst_wb_during: got %b exp 0", lu_wb); end
    step();
    reset = 0;
    #1;
    checks++; if (lu_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", lu_busy); end
    checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL rst_count: got %0d exp 0", stall_count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (lu_wb !== 1'b0) begin errors++; $display("FAIL rst_no_wb[%0d]: got %b exp 0", i, lu_wb); end
      step();
    end
    issue(15, 0);
    step();
    clear_inputs();
    #1;
    checks++; if (lu_busy !== 1'b1) begin errors++; $display("FAIL lat0_busy: got %b exp 1", lu_busy); end
    checks++; if (lu_wb !== 1'b1) begin errors++; $display("FAIL lat0_wb: got %b exp 1", lu_wb); end
    checks++; if (lu_wb_reg !== 5'd15) begin errors++; $display("FAIL lat0_reg: got %0d exp 15", lu_wb_reg); end
    step();
    checks++; if (lu_busy !== 1'b0) begin errors++; $display("FAIL lat0_idle: got %b exp 0", lu_busy); end
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch();
    test_long_op();
    test_back_to_back();
    test_freeze();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
